// File: rtl/amp_cfg_sequencer.sv
// amp_cfg_sequencer
// -----------------
// Writes the amplifier register table over I2C when the state controller
// asks for it. The table is a list of 16-bit {reg, data} entries. Each
// entry becomes one I2C register write, except when reg is 8'hFF: that
// entry is an inline pause of data*256 cycles. A write that is NACKed or
// gets no answer within TIMEOUT cycles is retried after RETRY_GAP idle
// cycles, up to MAX_RETRY extra times. After that the sequence aborts.
//
// Ports
//   clk_in            single clock
//   reset             synchronous, active-high
//   send_cfg_in       start request (rising edge, acted on only in IDLE)
//   tbl_index_out     table address (5 bits)
//   tbl_entry_in      {reg[15:8], data[7:0]} for tbl_index_out, same cycle
//   i2c_req_out       write request level to the I2C master
//   i2c_dev_addr_out  constant DEV_ADDR
//   i2c_reg_out       register address of the current write
//   i2c_data_out      data byte of the current write
//   i2c_done_in       one-cycle completion pulse from the master
//   i2c_nack_in       qualifies i2c_done_in; 1 = NACK
//   cfg_busy_out      sequence in progress
//   cfg_done_out      last sequence completed OK (level)
//   cfg_error_out     last sequence aborted (level)
//   cfg_state_out     current FSM state, for debug and checkers
//
// Handshake: i2c_req_out is a level that stays high, with reg/data stable,
// until the cycle in which i2c_done_in is sampled high. It drops in the
// following cycle. i2c_done_in is ignored in every other cycle.

module amp_cfg_sequencer #(
  parameter logic [6:0] DEV_ADDR    = 7'h4C,
  parameter int         NUM_ENTRIES = 16,
  parameter int         MAX_RETRY   = 3,
  parameter int         RETRY_GAP   = 1024,
  parameter int         TIMEOUT     = 65535
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic        send_cfg_in,
  output logic [4:0]  tbl_index_out,
  input  logic [15:0] tbl_entry_in,
  output logic        i2c_req_out,
  output logic [6:0]  i2c_dev_addr_out,
  output logic [7:0]  i2c_reg_out,
  output logic [7:0]  i2c_data_out,
  input  logic        i2c_done_in,
  input  logic        i2c_nack_in,
  output logic        cfg_busy_out,
  output logic        cfg_done_out,
  output logic        cfg_error_out,
  output logic [2:0]  cfg_state_out
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LOAD   = 3'd1;
  localparam logic [2:0] S_REQ    = 3'd2;
  localparam logic [2:0] S_GAP    = 3'd3;
  localparam logic [2:0] S_DELAY  = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;
  localparam logic [2:0] S_FAIL   = 3'd6;

  localparam int          RW       = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [4:0]  LAST_IDX = 5'(NUM_ENTRIES - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(RETRY_GAP - 1);
  localparam logic [7:0]  DELAY_REG = 8'hFF;

  logic [2:0]    state;
  logic          send_prev;
  logic [4:0]    idx;
  logic [7:0]    reg_q;
  logic [7:0]    data_q;
  logic [RW-1:0] retry;
  logic [15:0]   tmo_cnt;
  logic [15:0]   gap_cnt;
  logic [15:0]   dly_cnt;
  logic          busy;
  logic          done;
  logic          err;

  logic start_edge;
  logic attempt_ok;
  logic attempt_fail;
  logic advance;
  logic is_last;

  // The edge register samples in every state, so a start level that was
  // already high while busy does not fire once the FSM returns to IDLE.
  assign start_edge = send_cfg_in & ~send_prev;

  // A done in the same cycle as the timeout expiry takes priority. The
  // timeout compare is >=, so a saturated counter still reads as expired.
  assign attempt_ok   = (state == S_REQ) & i2c_done_in & ~i2c_nack_in;
  assign attempt_fail = (state == S_REQ) &
                        ((i2c_done_in & i2c_nack_in) |
                         (~i2c_done_in & (tmo_cnt >= TMO_LAST)));

  // A delay entry ends when its counter reaches 1 or 0. A pause of data*256
  // therefore lasts exactly that many cycles, and data==0 still spends one
  // cycle in DELAY.
  assign advance = attempt_ok | ((state == S_DELAY) & (dly_cnt <= 16'd1));
  assign is_last = (idx == LAST_IDX);

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state     <= S_IDLE;
      send_prev <= 1'b0;
      idx       <= 5'd0;
      reg_q     <= 8'h00;
      data_q    <= 8'h00;
      retry     <= '0;
      tmo_cnt   <= 16'd0;
      gap_cnt   <= 16'd0;
      dly_cnt   <= 16'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      send_prev <= send_cfg_in;
      if (advance) begin
        retry <= '0;
        if (is_last) begin
          // The index stays on the last entry; it never wraps.
          state <= S_FINISH;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          idx   <= idx + 5'd1;
          state <= S_LOAD;
        end
      end else begin
        case (state)
          S_IDLE: begin
            if (start_edge) begin
              state <= S_LOAD;
              idx   <= 5'd0;
              retry <= '0;
              busy  <= 1'b1;
              done  <= 1'b0;
              err   <= 1'b0;
            end
          end
          S_LOAD: begin
            reg_q   <= tbl_entry_in[15:8];
            data_q  <= tbl_entry_in[7:0];
            tmo_cnt <= 16'd0;
            if (tbl_entry_in[15:8] == DELAY_REG) begin
              state   <= S_DELAY;
              dly_cnt <= {tbl_entry_in[7:0], 8'h00};
            end else begin
              state <= S_REQ;
            end
          end
          S_REQ: begin
            if (attempt_fail) begin
              if (retry < RETRY_MAX) begin
                retry   <= retry + RW'(1);
                gap_cnt <= 16'd0;
                state   <= S_GAP;
              end else begin
                state <= S_FAIL;
                busy  <= 1'b0;
                err   <= 1'b1;
              end
            end else if (tmo_cnt != 16'hFFFF) begin
              tmo_cnt <= tmo_cnt + 16'd1;
            end
          end
          S_GAP: begin
            // The retry reuses the captured reg/data. The table is not
            // reloaded.
            if (gap_cnt >= GAP_LAST) begin
              state   <= S_REQ;
              tmo_cnt <= 16'd0;
            end else begin
              gap_cnt <= gap_cnt + 16'd1;
            end
          end
          S_DELAY: begin
            dly_cnt <= dly_cnt - 16'd1;
          end
          S_FINISH: state <= S_IDLE;
          S_FAIL:   state <= S_IDLE;
          default:  state <= S_IDLE;
        endcase
      end
    end
  end

  assign tbl_index_out    = idx;
  assign i2c_req_out      = (state == S_REQ);
  assign i2c_dev_addr_out = DEV_ADDR;
  assign i2c_reg_out      = reg_q;
  assign i2c_data_out     = data_q;
  assign cfg_busy_out     = busy;
  assign cfg_done_out     = done;
  assign cfg_error_out    = err;
  assign cfg_state_out    = state;

endmodule

// File: tb/tb_amp_cfg_sequencer.sv
// Testbench for amp_cfg_sequencer: a table of sequence scenarios plus
// hand-written reset and idle-done sequences. The I2C master model answers
// one cycle after a request rises and can NACK or stay silent. A scoreboard
// queue holds the expected write order, and each request is compared
// against it.

module tb_amp_cfg_sequencer;

  localparam int N   = 16;
  localparam int MR  = 3;
  localparam int GAP = 1024;
  localparam int TMO = 100;
  localparam logic [2:0] ST_IDLE = 3'd0;

  logic        clk_in = 1'b0;
  logic        reset;
  logic        send_cfg_in;
  logic [4:0]  tbl_index_out;
  logic [15:0] tbl_entry_in;
  logic        i2c_req_out;
  logic [6:0]  i2c_dev_addr_out;
  logic [7:0]  i2c_reg_out;
  logic [7:0]  i2c_data_out;
  logic        i2c_done_in;
  logic        i2c_nack_in;
  logic        cfg_busy_out;
  logic        cfg_done_out;
  logic        cfg_error_out;
  logic [2:0]  cfg_state_out;

  amp_cfg_sequencer #(
    .DEV_ADDR(7'h4C), .NUM_ENTRIES(N), .MAX_RETRY(MR),
    .RETRY_GAP(GAP), .TIMEOUT(TMO)
  ) dut (
    .clk_in(clk_in), .reset(reset), .send_cfg_in(send_cfg_in),
    .tbl_index_out(tbl_index_out), .tbl_entry_in(tbl_entry_in),
    .i2c_req_out(i2c_req_out), .i2c_dev_addr_out(i2c_dev_addr_out),
    .i2c_reg_out(i2c_reg_out), .i2c_data_out(i2c_data_out),
    .i2c_done_in(i2c_done_in), .i2c_nack_in(i2c_nack_in),
    .cfg_busy_out(cfg_busy_out), .cfg_done_out(cfg_done_out),
    .cfg_error_out(cfg_error_out), .cfg_state_out(cfg_state_out)
  );

  // ---------------- clock / cycle counter ----------------
  always #5 clk_in = ~clk_in;
  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  // ---------------- table memory ----------------
  logic [15:0] tbl [32];
  assign tbl_entry_in = tbl[tbl_index_out];

  // ---------------- counters / scoreboard ----------------
  int n_chk = 0;
  int n_fail = 0;
  logic [20:0] exp_q[$];   // {index, reg, data}
  int          exp_low_q[$];
  int          exp_hi_q[$];

  // Master-model configuration, written by the test only.
  int gen = 0;
  int nack_idx_cfg = -1;
  int nack_n_cfg = 0;
  int silent_idx_cfg = -1;
  bit poke_req = 1'b0;

  // Bus-process observations, written by the bus process only.
  int rise_count = 0;
  int first_rise_cyc = 0;
  int last_hi_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- bus monitor + I2C master model ----------------
  initial begin
    logic        req_prev;
    int          hi_run;
    int          low_run;
    int          cur_exp_hi;
    int          el;
    bit          cur_valid;
    logic [20:0] cur_item;
    int          seen_gen;
    int          rise_gen;
    int          nacks_given;
    bit          poke_seen;
    req_prev = 1'b0; hi_run = 0; low_run = 0; cur_exp_hi = -1; cur_valid = 1'b0;
    cur_item = '0; seen_gen = 0; rise_gen = 0; nacks_given = 0; poke_seen = 1'b0;
    i2c_done_in = 1'b0;
    i2c_nack_in = 1'b0;
    forever begin
      @(negedge clk_in);
      i2c_done_in = 1'b0;
      i2c_nack_in = 1'b0;
      if (gen != seen_gen) begin
        seen_gen = gen;
        nacks_given = 0;
      end
      if (i2c_req_out && !req_prev) begin
        rise_count++;
        if (rise_gen != gen) begin
          first_rise_cyc = cyc;
          rise_gen = gen;
        end
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_req: index %0d reg %h data %h, expected no request",
                   tbl_index_out, i2c_reg_out, i2c_data_out);
          cur_valid = 1'b0;
          cur_exp_hi = -1;
        end else begin
          cur_item   = exp_q.pop_front();
          el         = exp_low_q.pop_front();
          cur_exp_hi = exp_hi_q.pop_front();
          cur_valid  = 1'b1;
          chk("req_index", 32'(tbl_index_out), 32'(cur_item[20:16]));
          chk("req_reg",   32'(i2c_reg_out),   32'(cur_item[15:8]));
          chk("req_data",  32'(i2c_data_out),  32'(cur_item[7:0]));
          chk("dev_addr",  32'(i2c_dev_addr_out), 32'h4C);
          if (el >= 0) chk("req_low_cycles", low_run, el);
        end
        hi_run = 0;
      end
      if (!i2c_req_out && req_prev && cur_exp_hi >= 0)
        chk("req_high_cycles", hi_run, cur_exp_hi);
      if (i2c_req_out) begin
        hi_run++;
        low_run = 0;
        last_hi_cyc = cyc;
        if (hi_run > 1 && cur_valid)
          chk("req_stable", 32'({i2c_reg_out, i2c_data_out}), 32'(cur_item[15:0]));
        if (hi_run == 2 && int'(tbl_index_out) != silent_idx_cfg) begin
          i2c_done_in = 1'b1;
          if (int'(tbl_index_out) == nack_idx_cfg && nacks_given < nack_n_cfg) begin
            i2c_nack_in = 1'b1;
            nacks_given++;
          end
        end
      end else begin
        low_run++;
      end
      if (poke_req != poke_seen) begin
        poke_seen = poke_req;
        i2c_done_in = 1'b1;
      end
      req_prev = i2c_req_out;
    end
  end

  // ---------------- scenario table ----------------
  typedef struct {
    int         nack_idx;
    int         nack_n;
    int         silent_idx;
    int         delay_idx;
    logic [7:0] delay_val;
    bit         poke;
    bit         exp_done;
    bit         exp_err;
    int         exp_reqs;
  } case_t;

  case_t cases [6];

  task automatic fill_table();
    for (int i = 0; i < 32; i++)
      tbl[i] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
  endtask

  task automatic run_case(input case_t c);
    int nxt_low;
    int fails;
    int tries;
    int start;
    int waited;
    int rise_base;
    int fall;
    int d;
    fill_table();
    if (c.delay_idx >= 0) tbl[c.delay_idx] = {8'hFF, c.delay_val};
    gen++;
    nack_idx_cfg   = c.nack_idx;
    nack_n_cfg     = c.nack_n;
    silent_idx_cfg = c.silent_idx;
    // Expected write order and the req low/high run lengths around each one.
    nxt_low = -1;
    for (int i = 0; i < N; i++) begin
      if (i == c.delay_idx) begin
        d = (c.delay_val == 8'd0) ? 1 : int'(c.delay_val) * 256;
        if (nxt_low >= 0) nxt_low = d + 2;
      end else begin
        fails = (i == c.nack_idx) ? c.nack_n : ((i == c.silent_idx) ? 99 : 0);
        tries = (fails > MR) ? MR + 1 : fails + 1;
        for (int a = 0; a < tries; a++) begin
          exp_q.push_back({5'(i), tbl[i]});
          exp_low_q.push_back((a == 0) ? nxt_low : GAP);
          exp_hi_q.push_back((i == c.silent_idx) ? TMO : 2);
        end
        if (fails > MR) break;
        nxt_low = 1;
      end
    end
    rise_base = rise_count;
    @(negedge clk_in);
    send_cfg_in = 1'b1;
    start = cyc;
    @(negedge clk_in);
    send_cfg_in = 1'b0;
    chk("busy_after_start", 32'(cfg_busy_out), 1);
    chk("done_cleared", 32'(cfg_done_out), 0);
    chk("error_cleared", 32'(cfg_error_out), 0);
    waited = 0;
    while (cfg_busy_out && waited < 20000) begin
      @(negedge clk_in);
      waited++;
      if (c.poke && waited == 10) send_cfg_in = 1'b1;
      if (c.poke && waited == 11) send_cfg_in = 1'b0;
    end
    if (cfg_busy_out) begin
      n_chk++;
      n_fail++;
      $display("FAIL busy_timeout: busy still 1 after %0d cycles, required 0", waited);
    end
    fall = cyc;
    chk("flags_latency", fall, last_hi_cyc + 1);
    chk("cfg_done", 32'(cfg_done_out), 32'(c.exp_done));
    chk("cfg_error", 32'(cfg_error_out), 32'(c.exp_err));
    chk("busy_low", 32'(cfg_busy_out), 0);
    chk("first_req_latency", first_rise_cyc, start + 2);
    if (c.nack_idx < 0 && c.silent_idx < 0 && c.delay_idx < 0)
      chk("sequence_length", fall - start + 1, 2 + 3 * N);
    repeat (6) @(negedge clk_in);
    chk("state_idle", 32'(cfg_state_out), 32'(ST_IDLE));
    chk("req_count", rise_count - rise_base, c.exp_reqs);
    chk("queue_drained", exp_q.size(), 0);
    chk("done_level_held", 32'(cfg_done_out), 32'(c.exp_done));
    exp_q.delete();
    exp_low_q.delete();
    exp_hi_q.delete();
  endtask

  // ---------------- main test ----------------
  initial begin
    int waited;
    int rise_base;
    case_t pc;
    // nack_idx nack_n silent delay dval poke done err reqs
    cases[0] = '{-1, 0, -1, -1, 8'h00, 1'b0, 1'b1, 1'b0, 16};
    cases[1] = '{ 3, 2, -1, -1, 8'h00, 1'b0, 1'b1, 1'b0, 18};
    cases[2] = '{ 5, 4, -1, -1, 8'h00, 1'b0, 1'b0, 1'b1, 9};
    cases[3] = '{-1, 0,  0, -1, 8'h00, 1'b0, 1'b0, 1'b1, 4};
    cases[4] = '{-1, 0, -1,  2, 8'h04, 1'b0, 1'b1, 1'b0, 15};
    cases[5] = '{-1, 0, -1,  4, 8'h00, 1'b0, 1'b1, 1'b0, 15};
    pc       = '{-1, 0, -1, -1, 8'h00, 1'b1, 1'b1, 1'b0, 16};

    for (int i = 0; i < 32; i++) tbl[i] = 16'h0000;
    reset = 1'b1;
    send_cfg_in = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("rst_req", 32'(i2c_req_out), 0);
    chk("rst_index", 32'(tbl_index_out), 0);
    chk("rst_regdata", 32'({i2c_reg_out, i2c_data_out}), 0);
    chk("rst_busy", 32'(cfg_busy_out), 0);
    chk("rst_done", 32'(cfg_done_out), 0);
    chk("rst_error", 32'(cfg_error_out), 0);
    chk("rst_state", 32'(cfg_state_out), 32'(ST_IDLE));
    chk("rst_dev_addr", 32'(i2c_dev_addr_out), 32'h4C);
    reset = 1'b0;

    // A done pulse while idle must not move the FSM.
    @(negedge clk_in);
    poke_req = ~poke_req;
    repeat (3) @(negedge clk_in);
    chk("idle_done_state", 32'(cfg_state_out), 32'(ST_IDLE));
    chk("idle_done_busy", 32'(cfg_busy_out), 0);
    chk("idle_done_flags", 32'({cfg_done_out, cfg_error_out}), 0);

    for (int k = 0; k < 6; k++) run_case(cases[k]);

    // Reset during the request for entry 7, then a fresh sequence.
    fill_table();
    gen++;
    nack_idx_cfg = -1;
    silent_idx_cfg = -1;
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({5'(i), tbl[i]});
      exp_low_q.push_back((i == 0) ? -1 : 1);
      exp_hi_q.push_back((i == 7) ? -1 : 2);
    end
    rise_base = rise_count;
    @(negedge clk_in);
    send_cfg_in = 1'b1;
    @(negedge clk_in);
    send_cfg_in = 1'b0;
    waited = 0;
    while (!(i2c_req_out && tbl_index_out == 5'd7) && waited < 2000) begin
      @(negedge clk_in);
      waited++;
    end
    chk("reached_entry7", 32'(i2c_req_out && tbl_index_out == 5'd7), 1);
    reset = 1'b1;
    @(negedge clk_in);
    chk("reset_req_drop", 32'(i2c_req_out), 0);
    chk("reset_busy", 32'(cfg_busy_out), 0);
    chk("reset_index", 32'(tbl_index_out), 0);
    chk("reset_state", 32'(cfg_state_out), 32'(ST_IDLE));
    chk("reset_regdata", 32'({i2c_reg_out, i2c_data_out}), 0);
    reset = 1'b0;
    repeat (3) @(negedge clk_in);
    chk("reset_req_count", rise_count - rise_base, 8);
    chk("reset_queue", exp_q.size(), 0);
    exp_q.delete();
    exp_low_q.delete();
    exp_hi_q.delete();

    // Restart from index 0, with a start edge injected while busy.
    run_case(pc);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

endmodule

// File: doc/amp_cfg_sequencer.md
# amp_cfg_sequencer

Configuration sequencer between the amplifier state controller and the byte-level I2C master. A `send_cfg` request makes it walk a register table of (register, data) pairs and issue one I2C register write per entry through a request/done handshake. It retries NACKed or timed-out writes, honours inline delay entries, and reports busy/done/error back to the state controller. It is the only block that drives the I2C master's command port.

## Interface
- `DEV_ADDR`, 7'h4C: 7-bit amplifier I2C device address, constant on `i2c_dev_addr_out`.
- `NUM_ENTRIES`, 16: table length, 1..32.
- `MAX_RETRY`, 3: extra attempts per entry after the first failure.
- `RETRY_GAP`, 1024: idle cycles between a failure and the retry.
- `TIMEOUT`, 65535: cycles without `i2c_done_in` before an attempt counts as failed.
- `clk_in`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `send_cfg_in`, in, 1: start request; rising edge triggers.
- `tbl_index_out`, out, 5: table address.
- `tbl_entry_in`, in, 16: {reg[15:8], data[7:0]}; combinational, valid in the same cycle as the index.
- `i2c_req_out`, out, 1: write request to the I2C master.
- `i2c_dev_addr_out`, out, 7: equals `DEV_ADDR`.
- `i2c_reg_out`, out, 8: register address; stable while req is high.
- `i2c_data_out`, out, 8: write data; stable while req is high.
- `i2c_done_in`, in, 1: one-cycle completion pulse from the master.
- `i2c_nack_in`, in, 1: qualifies `i2c_done_in`; 1 means NACK.
- `cfg_busy_out`, out, 1: sequence in progress.
- `cfg_done_out`, out, 1: last sequence completed OK (level).
- `cfg_error_out`, out, 1: last sequence aborted (level).

## Operation
- States: IDLE, LOAD, REQ, GAP, DELAY, FINISH, FAIL.
- IDLE: `send_cfg_in` rising edge (registered prev-sample compare) → LOAD. Entering LOAD sets index=0 and retry=0, clears done and error, and sets busy.
- LOAD: capture `tbl_entry_in` at the current index into a reg/data register.
  - reg==8'hFF: delay entry → DELAY with counter = data×256.
  - Otherwise → REQ.
- REQ: `i2c_req_out`=1 and the timeout counter runs.
  - `i2c_done_in` & !nack: success. Advance to the next entry: index+1 and retry=0. If index was `NUM_ENTRIES`-1 → FINISH, else → LOAD.
  - `i2c_done_in` & nack, or timeout expired: failure. If retry<`MAX_RETRY`, retry+1 → GAP. Otherwise → FAIL.
- GAP: count `RETRY_GAP` cycles → REQ with the same entry (no reload).
- DELAY: count down to 0, then advance to the next entry as on success. data==0 gives zero delay; advance in the next cycle.
- FINISH: busy=0, done=1 → IDLE.
- FAIL: busy=0, error=1 → IDLE. Done and error are never both 1.
- Start edge while busy: ignored; it is not queued.
- Edge detector keeps sampling in every state. An edge must be a 0→1 transition that completes in IDLE to trigger.
- `i2c_done_in` outside REQ: ignored.
- `reset` mid-sequence: next cycle IDLE, req drops immediately. The I2C master must tolerate an abandoned request.
- Counters:
  - Timeout: 16 bits, saturating compare.
  - Delay: 16 bits.
  - Retry: clog2(`MAX_RETRY`+1) bits.
  - Index: 5 bits; no wrap, terminates at `NUM_ENTRIES`-1.

## Timing
- Reset values: `i2c_req_out`=0, `tbl_index_out`=0, reg/data=0, busy=0, done=0, error=0, state IDLE, edge register=0.
- Start latency:
  - Edge sampled high at cycle t → LOAD at t+1 (busy=1).
  - Req=1 at t+2 with reg/data valid.
- Handshake: req is a level and stays high through the cycle in which `i2c_done_in` is sampled. It drops the cycle after. Next entry's req rises 2 cycles after done (LOAD, then REQ).
- Retry: req low for exactly `RETRY_GAP` cycles after the failing done, then rises with identical reg/data.
- Timeout: failure declared when `TIMEOUT` cycles elapse in REQ without done.
- Completion: done/error assert 1 cycle after the final done/failure (FINISH/FAIL). Busy deasserts in the same cycle.
- Minimum full sequence with an ideal 1-cycle master: 2 + 3×`NUM_ENTRIES` cycles.

## Test plan
- Reset, then start pulse, 16 entries, master acks 1 cycle after each req: 16 writes in table order; `i2c_reg_out`/`i2c_data_out` match the table; done=1 and busy=0 one cycle after the 16th done; error stays 0.
- Entry 3 NACKed twice, then acked: entry 3 issued 3 times, each retry req rising exactly 1024 cycles after the failing done; sequence completes with done=1.
- Entry 5 NACKed 4 times (`MAX_RETRY`=3): 4 attempts, then error=1, done=0, busy=0; no entry 6 request ever issued.
- Master never answers on entry 0 (`TIMEOUT`=100 for this test): req drops after 100 cycles; retries follow; error=1 after 4 timeouts.
- Entry 2 = 16'hFF04: no I2C request for entry 2; req for entry 3 rises 1024+2 cycles after entry 2 is loaded (±1, check exact).
- `reset` asserted mid-REQ at entry 7, then a second start pulse: req low the cycle after reset; new sequence restarts at index 0. Start edge during busy is ignored (exactly 16 writes observed).
